// File: rtl/depuncturer_pkg.sv
// Shared rx/tx coding constants: rate codes, puncture periods and puncture
// patterns. Pattern bit k is column k of the pattern (1 = bit transmitted).
// The transmit-side puncturer uses the same vectors.
package depuncturer_pkg;

  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;

  localparam logic [2:0] PERIOD_1_2 = 3'd2;
  localparam logic [2:0] PERIOD_2_3 = 3'd3;
  localparam logic [2:0] PERIOD_3_4 = 3'd4;

  localparam int unsigned PAT_W = 4;

  // A:1   B:1
  localparam logic [PAT_W-1:0] PUNC_A_1_2 = 4'b0001;
  localparam logic [PAT_W-1:0] PUNC_B_1_2 = 4'b0001;
  // A:11  B:10
  localparam logic [PAT_W-1:0] PUNC_A_2_3 = 4'b0011;
  localparam logic [PAT_W-1:0] PUNC_B_2_3 = 4'b0001;
  // A:110 B:101
  localparam logic [PAT_W-1:0] PUNC_A_3_4 = 4'b0011;
  localparam logic [PAT_W-1:0] PUNC_B_3_4 = 4'b0101;

  // Reserved code 11 behaves as rate 1/2.
  function automatic logic [1:0] norm_rate(input logic [1:0] r);
    return (r == 2'b11) ? RATE_1_2 : r;
  endfunction

  // Number of received bits per puncture period.
  function automatic logic [2:0] period_of(input logic [1:0] r);
    case (r)
      RATE_2_3: return PERIOD_2_3;
      RATE_3_4: return PERIOD_3_4;
      default:  return PERIOD_1_2;
    endcase
  endfunction

  function automatic logic [PAT_W-1:0] pat_a(input logic [1:0] r);
    case (r)
      RATE_2_3: return PUNC_A_2_3;
      RATE_3_4: return PUNC_A_3_4;
      default:  return PUNC_A_1_2;
    endcase
  endfunction

  function automatic logic [PAT_W-1:0] pat_b(input logic [1:0] r);
    case (r)
      RATE_2_3: return PUNC_B_2_3;
      RATE_3_4: return PUNC_B_3_4;
      default:  return PUNC_B_1_2;
    endcase
  endfunction

endpackage

// File: rtl/depuncturer.sv
// Depuncturer: regroups the serial deinterleaved coded-bit stream into
// (A,B) encoder-output pairs, inserting erasures where the transmitter
// punctured bits so the Viterbi decoder always sees rate-1/2 pairs.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in, in_valid, sof   input bit/metric, its qualifier, start-of-frame
//   rate                coding rate code (latched only with in_valid & sof)
//   out_a, out_b        output pair (erased fields driven 0)
//   era_a, era_b        erasure flags for out_a / out_b
//   out_valid           one-cycle strobe per emitted pair
module depuncturer
  import depuncturer_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in,
  input  logic         in_valid,
  input  logic         sof,
  input  logic [1:0]   rate,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         era_a,
  output logic         era_b,
  output logic         out_valid
);

  logic [1:0]       active_rate;
  logic [1:0]       phase;
  logic [W-1:0]     held_a;

  logic [1:0]       eff_rate;
  logic [1:0]       eff_phase;
  logic [1:0]       last_phase;
  logic [1:0]       col;
  logic [PAT_W-1:0] pa;
  logic [PAT_W-1:0] pb;
  logic             emit;
  logic             kill_a;
  logic             kill_b;

  // A sof bit starts a new period at phase 0 under the newly presented rate.
  // Phase p>0 completes pattern column p-1; a cleared pattern bit is an erasure.
  always_comb begin
    eff_rate   = sof ? norm_rate(rate) : active_rate;
    eff_phase  = sof ? 2'd0 : phase;
    last_phase = 2'(period_of(eff_rate) - 3'd1);
    col        = eff_phase - 2'd1;
    pa         = pat_a(eff_rate);
    pb         = pat_b(eff_rate);
    emit       = (eff_phase != 2'd0);
    kill_a     = ~pa[col];
    kill_b     = ~pb[col];
  end

  // Phase counter, held-A register and registered output pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_rate <= RATE_1_2;
      phase       <= 2'd0;
      held_a      <= '0;
      out_a       <= '0;
      out_b       <= '0;
      era_a       <= 1'b0;
      era_b       <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (sof) begin
          active_rate <= eff_rate;
        end
        phase <= (eff_phase == last_phase) ? 2'd0 : eff_phase + 2'd1;
        if (!emit) begin
          held_a <= in;
        end else begin
          out_valid <= 1'b1;
          era_a     <= kill_a;
          era_b     <= kill_b;
          // Full column pairs held A with this bit; a lone A or B bit is
          // routed to its own field and the other field zeroed.
          out_a     <= kill_a ? '0 : (kill_b ? in : held_a);
          out_b     <= kill_b ? '0 : in;
        end
      end
    end
  end

endmodule

// File: tb/tb_depuncturer.sv
// Testbench for depuncturer: directed scenarios plus randomized traffic,
// checked cycle by cycle against a frame-position reference model.
module tb_depuncturer;

  localparam int unsigned W  = 3;
  localparam int unsigned VW = 2 * W + 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic         in_valid;
  logic         sof;
  logic [1:0]   rate;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         era_a;
  logic         era_b;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  // Reference model: bits counted since the last sof/reset, period per rate.
  int           m_per;
  int           m_cnt;
  logic [W-1:0] m_prev;
  logic         exp_v;
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  logic         exp_ea;
  logic         exp_eb;

  depuncturer #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .sof      (sof),
    .rate     (rate),
    .out_a    (out_a),
    .out_b    (out_b),
    .era_a    (era_a),
    .era_b    (era_b),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] got_vec();
    return {out_valid, era_a, era_b, out_a, out_b};
  endfunction

  function automatic logic [VW-1:0] want_vec();
    return {exp_v, exp_ea, exp_eb, exp_a, exp_b};
  endfunction

  function automatic int period_for(input int r);
    if (r == 1) return 3;
    if (r == 2) return 4;
    return 2;
  endfunction

  task automatic model_reset();
    m_per  = 2;
    m_cnt  = 0;
    m_prev = '0;
    exp_v  = 1'b0;
    exp_a  = '0;
    exp_b  = '0;
    exp_ea = 1'b0;
    exp_eb = 1'b0;
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge.
  task automatic step(input int val, input bit v, input bit s, input int r);
    int pos;
    in       = W'(val);
    in_valid = v;
    sof      = s;
    rate     = 2'(r);
    exp_v    = 1'b0;
    if (v) begin
      if (s) begin
        m_per = period_for(r);
        m_cnt = 0;
      end
      pos   = m_cnt % m_per;
      m_cnt = m_cnt + 1;
      case (pos)
        0: m_prev = W'(val);
        1: begin exp_v = 1; exp_a = m_prev;  exp_b = W'(val); exp_ea = 0; exp_eb = 0; end
        2: begin exp_v = 1; exp_a = W'(val); exp_b = '0;      exp_ea = 0; exp_eb = 1; end
        default: begin exp_v = 1; exp_a = '0; exp_b = W'(val); exp_ea = 1; exp_eb = 0; end
      endcase
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    sof      = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    in = '0; rate = 2'b00; in_valid = 0; sof = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    checks++;
    if (got_vec() !== want_vec() || got_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", got_vec());
    end
  endtask

  task automatic test_rate_1_2();
    int bits [4] = '{1, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      step(bits[i], 1'b1, i == 0, 0);
      checks++;
      if (got_vec() !== want_vec()) begin
        errors++;
        $display("FAIL rate_1_2 bit %0d: got %h want %h", i, got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_rate_3_4();
    int bits [8] = '{1, 1, 0, 1, 0, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      step(bits[i], 1'b1, i == 0, 2);
      checks++;
      if (got_vec() !== want_vec()) begin
        errors++;
        $display("FAIL rate_3_4 bit %0d: got %h want %h", i, got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_rate_2_3();
    int bits [6] = '{1, 0, 1, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      step(bits[i], 1'b1, i == 0, 1);
      checks++;
      if (got_vec() !== want_vec()) begin
        errors++;
        $display("FAIL rate_2_3 bit %0d: got %h want %h", i, got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_gap();
    // A0, three idle cycles, B0, then A1 and B2 keep their phase alignment.
    int vals [7] = '{5, 0, 0, 0, 2, 6, 3};
    bit vld  [7] = '{1, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      step(vals[i], vld[i], i == 0, 2);
      checks++;
      if (got_vec() !== want_vec()) begin
        errors++;
        $display("FAIL gap cycle %0d: got %h want %h", i, got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_resync();
    // 3/4 frame cut after 2 bits, new 1/2 frame, rate wiggles mid-frame,
    // then a lone held A discarded by another sof.
    int vals [9] = '{7, 1, 4, 6, 2, 3, 5, 1, 2};
    bit sofs [9] = '{1, 0, 1, 0, 0, 0, 1, 1, 0};
    int rts  [9] = '{2, 2, 0, 2, 1, 2, 0, 3, 2};
    for (int i = 0; i < 9; i++) begin
      step(vals[i], 1'b1, sofs[i], rts[i]);
      checks++;
      if (got_vec() !== want_vec()) begin
        errors++;
        $display("FAIL resync bit %0d: got %h want %h", i, got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(3, 1'b1, 1'b1, 2);
    step(4, 1'b1, 1'b0, 2);
    do_reset();
    checks++;
    if (got_vec() !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %h want 0", got_vec());
    end
    for (int i = 0; i < 4; i++) begin
      step(i + 2, 1'b1, 1'b0, 2);
      checks++;
      if (got_vec() !== want_vec()) begin
        errors++;
        $display("FAIL reset_mid bit %0d: got %h want %h", i, got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, (1 << W) - 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)));
      checks++;
      if (got_vec() !== want_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h want %h", i, got_vec(), want_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    // Continuous rate changes frame to frame with no idle cycles.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 5; i++) begin
        step(int'($urandom_range(0, (1 << W) - 1)), 1'b1, i == 0, f % 4);
        checks++;
        if (got_vec() !== want_vec()) begin
          errors++;
          $display("FAIL b2b frame %0d bit %0d: got %h want %h", f, i, got_vec(), want_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rate_1_2();
    test_rate_3_4();
    test_rate_2_3();
    test_gap();
    test_resync();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
